// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and helpers for the Rijndael round datapath.
//   BYTE_W        - bits per state byte
//   ROWS          - rows in the Rijndael state
//   pipe_state_e  - occupancy of a registered stage with one skid entry
//   shift_offset  - ShiftRows row offset Cr for a given column count
//   nb_legal      - true for the column counts Rijndael defines (4, 6, 8)
package aes_pkg;

   localparam int BYTE_W = 8;
   localparam int ROWS   = 4;

   // EMPTY: nothing held; ONE: main register valid; FULL: main and skid valid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_e;

   // Row 0 never moves; 8-column states use the wider 1/3/4 offsets.
   function automatic int shift_offset(input int nb, input int row);
      int off;
      off = 0;
      if (row != 0) begin
         if (nb == 8) begin
            case (row)
               1:       off = 1;
               2:       off = 3;
               default: off = 4;
            endcase
         end else begin
            off = row;
         end
      end
      return off;
   endfunction

   function automatic bit nb_legal(input int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

endpackage

// File: rtl/shift_rows_core.sv
// shift_rows_core: combinational ShiftRows / InvShiftRows permutation.
//   in   - state, byte k = in[8k+:8] is row k%4, column k/4
//   inv  - 0 rotates each row left by Cr, 1 rotates it right by Cr
//   out  - permuted state, same byte layout as in
// Every source index is an elaboration constant, so each output byte is a
// plain 2:1 byte mux between its forward and inverse source.
module shift_rows_core
   import aes_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [0:32*NB-1] in,
   input  logic             inv,
   output logic [0:32*NB-1] out
);

   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         localparam int SH    = shift_offset(NB, r);
         localparam int SRC_F = (c + SH) % NB;
         // NB is added first so the modulo operand is never negative.
         localparam int SRC_I = (c + NB - SH) % NB;

         assign out[BYTE_W*(ROWS*c + r) +: BYTE_W] =
            inv ? in[BYTE_W*(ROWS*SRC_I + r) +: BYTE_W]
                : in[BYTE_W*(ROWS*SRC_F + r) +: BYTE_W];
      end
   end

endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered ShiftRows / InvShiftRows stage with a
// two-entry (main + skid) buffer, sustaining one block per cycle.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake
//   in_data/in_inv      - state block and direction (sampled on accept)
//   in_tag              - sideband carried alongside the block
//   out_valid/out_ready - downstream handshake
//   out_data/out_tag    - permuted block and its tag
//
// Handshake: a block moves on a rising clk edge when valid && ready are both
// high on that side. A producer holding valid may not be assumed to be
// accepted until that edge. in_ready is registered and is low only while the
// skid entry is occupied, so it never depends combinationally on out_ready.
// While out_valid && !out_ready the output block and tag are held stable.
module shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int NB    = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:32*NB-1] in_data,
   input  logic             in_inv,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:32*NB-1] out_data,
   output logic [TAG_W-1:0] out_tag
);

   localparam int W = 32 * NB;

   if (!nb_legal(NB)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("shift_rows_pipe: TAG_W must be at least 1");
   end

   // Permuting ahead of the registers means neither register stores in_inv.
   logic [0:W-1] perm_data;

   shift_rows_core #(
      .NB (NB)
   ) u_core (
      .in  (in_data),
      .inv (in_inv),
      .out (perm_data)
   );

   pipe_state_e      state;
   pipe_state_e      state_nxt;
   logic             skid_valid;
   logic [0:W-1]     skid_data;
   logic [TAG_W-1:0] skid_tag;

   logic accept;
   logic load_main;
   logic load_skid;
   logic skid_to_main;

   assign accept = in_valid && in_ready;

   always_comb begin
      state_nxt    = state;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               state_nxt = ST_ONE;
               load_main = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && !out_ready) begin
               state_nxt = ST_FULL;
               load_skid = 1'b1;
            end else if (accept) begin
               // Current block leaves on this edge; the new one replaces it.
               load_main = 1'b1;
            end else if (out_ready) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               state_nxt    = ST_ONE;
               skid_to_main = skid_valid;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
   end

   // Handshake flags are registered decodes of the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_EMPTY;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         in_ready   <= (state_nxt != ST_FULL);
         out_valid  <= (state_nxt != ST_EMPTY);
         skid_valid <= (state_nxt == ST_FULL);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_tag   <= '0;
         skid_data <= '0;
         skid_tag  <= '0;
      end else begin
         if (load_main) begin
            out_data <= perm_data;
            out_tag  <= in_tag;
         end else if (skid_to_main) begin
            out_data <= skid_data;
            out_tag  <= skid_tag;
         end
         if (load_skid) begin
            skid_data <= perm_data;
            skid_tag  <= in_tag;
         end
      end
   end

endmodule
